dwc_pe_mc: RTL

- Multi-channel, pipelined depthwise-convolution PE; successor to the single-channel 3x3 PE.
- Computes CH independent KxK signed dot products per beat (one window per channel, one kernel per channel), adds per-channel bias, then applies rounding right-shift, saturation and optional ReLU.
- Uses valid/ready handshakes on feature and output streams, and double-buffered weights so kernels can be swapped between beats without draining.
- Sits between the line-buffer/window generator and the pointwise-conv stage.

---
 rtl/dwc_pkg.sv | 79 +++++++
 rtl/dwc_lane.sv | 108 ++++++++++
 rtl/dwc_pe_mc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dwc_pkg.sv
// dwc_pkg: shared definitions for the depthwise-convolution PE family.
//   - default geometry/width constants and derived packing constants
//   - clog2 helper and accumulator-width legality check
//   - round_sat: rounding arithmetic right shift, saturation and optional
//     ReLU, shared with the pointwise PE.
package dwc_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_K_SIZE = 3;
    localparam int DEF_CH     = 4;
    localparam int DEF_BWIDTH = 16;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_OWIDTH = 8;
    localparam int DEF_SH_W   = 5;

    // Taps per channel and the bit span of one channel's window/kernel.
    localparam int DEF_K2       = DEF_K_SIZE * DEF_K_SIZE;
    localparam int DEF_CH_BITS  = DEF_K2 * DEF_DWIDTH;
    localparam int DEF_ALL_BITS = DEF_CH * DEF_CH_BITS;

    // Working width of round_sat. Any legal ACC_W (plus the rounding carry)
    // fits with room to spare, so the result is exact.
    localparam int RS_W = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // The adder tree plus bias must never overflow the accumulator.
    function automatic bit acc_w_legal(input int dw, input int k2,
                                       input int bw, input int accw);
        return (accw >= 2 * dw + clog2(k2)) && (accw >= bw) && (accw < RS_W - 1);
    endfunction

    // Channel 0 and tap 0 sit in the most significant positions.
    function automatic int chan_lsb(input int chan, input int nch, input int chan_bits);
        return (nch - 1 - chan) * chan_bits;
    endfunction

    function automatic int tap_lsb(input int tap, input int k2, input int dw);
        return (k2 - 1 - tap) * dw;
    endfunction

    // r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, then saturate to
    // an ow-bit signed range and optionally clamp negatives to zero.
    // The caller keeps the low ow bits of the return value.
    function automatic logic signed [RS_W-1:0] round_sat(
        input logic signed [RS_W-1:0] acc,
        input int                     shift,
        input int                     ow,
        input logic                   relu
    );
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] rnd;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        one = 1;
        rnd = (shift > 0) ? (one <<< (shift - 1)) : '0;
        r   = (acc + rnd) >>> shift;
        hi  = (one <<< (ow - 1)) - one;
        lo  = -hi - one;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        if (relu && (r < 0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dwc_lane.sv
// dwc_lane: one channel of the depthwise PE.
//   S1: K2 signed products (active weights) and the bias are registered.
//   S2: balanced adder tree of the products plus bias, in ACC_W.
//   S3: rounding shift, saturation, optional ReLU -> result.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears all stages)
//   adv          all stages load when high, hold when low
//   wgt, feat    K2 taps of DWIDTH, tap 0 in the MSBs
//   bias         signed channel bias (from the active bank)
//   cfg_shift    right-shift amount, used in S3
//   cfg_relu     clamp negatives to 0, used in S3
//   result       registered S3 output
module dwc_lane
    import dwc_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int K2     = DEF_K2,
    parameter int BWIDTH = DEF_BWIDTH,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OWIDTH = DEF_OWIDTH,
    parameter int SH_W   = DEF_SH_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adv,
    input  logic [K2*DWIDTH-1:0]     wgt,
    input  logic [K2*DWIDTH-1:0]     feat,
    input  logic signed [BWIDTH-1:0] bias,
    input  logic [SH_W-1:0]          cfg_shift,
    input  logic                     cfg_relu,
    output logic [OWIDTH-1:0]        result
);

    localparam int PW   = 2 * DWIDTH;
    localparam int LVLS = clog2(K2);
    localparam int NP   = 1 << LVLS;   // leaf count, padded to a power of two

    logic signed [PW-1:0]     prod_next [K2];
    logic signed [PW-1:0]     prod_reg  [K2];
    logic signed [BWIDTH-1:0] bias_s1_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  acc_s2_reg;
    logic [OWIDTH-1:0]        result_next;
    logic [OWIDTH-1:0]        result_reg;

    genvar gi;
    genvar gj;

    // S1 multipliers.
    generate
        for (gi = 0; gi < K2; gi++) begin : g_tap
            localparam int LSB = tap_lsb(gi, K2, DWIDTH);
            logic signed [DWIDTH-1:0] w_tap;
            logic signed [DWIDTH-1:0] f_tap;
            assign w_tap         = wgt[LSB +: DWIDTH];
            assign f_tap         = feat[LSB +: DWIDTH];
            assign prod_next[gi] = PW'(w_tap) * PW'(f_tap);
        end
    endgenerate

    // S2 adder tree: level 0 holds the sign-extended products (zero padded),
    // each further level halves the node count.
    generate
        for (gi = 0; gi <= LVLS; gi++) begin : g_lvl
            localparam int N = NP >> gi;
            logic signed [ACC_W-1:0] node [N];
            for (gj = 0; gj < N; gj++) begin : g_node
                if (gi == 0) begin : g_leaf
                    if (gj < K2) begin : g_used
                        assign node[gj] = ACC_W'(prod_reg[gj]);
                    end else begin : g_pad
                        assign node[gj] = '0;
                    end
                end else begin : g_add
                    assign node[gj] = g_lvl[gi-1].node[2*gj] + g_lvl[gi-1].node[2*gj+1];
                end
            end
        end
    endgenerate

    assign acc_next = g_lvl[LVLS].node[0] + ACC_W'(bias_s1_reg);

    // S3 post-processing; configuration is sampled as the beat passes.
    always_comb begin
        result_next = OWIDTH'(round_sat(RS_W'(acc_s2_reg), int'(cfg_shift), OWIDTH, cfg_relu));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K2; i++) begin
                prod_reg[i] <= '0;
            end
            bias_s1_reg <= '0;
            acc_s2_reg  <= '0;
            result_reg  <= '0;
        end else if (adv) begin
            for (int i = 0; i < K2; i++) begin
                prod_reg[i] <= prod_next[i];
            end
            bias_s1_reg <= bias;
            acc_s2_reg  <= acc_next;
            result_reg  <= result_next;
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/dwc_pe_mc.sv
// dwc_pe_mc: multi-channel pipelined depthwise-convolution PE.
// Computes CH independent KxK signed dot products per beat, adds a bias per
// channel, then rounds, saturates and optionally applies ReLU. Latency is 3
// cycles from accept to out_valid; all stages stall together.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_shift, cfg_relu   post-processing configuration (sampled in S3)
//   wgt_data, wgt_bias    kernels/biases, channel 0 and tap 0 in the MSBs
//   wgt_load              write wgt_data/wgt_bias into the shadow bank
//   wgt_commit            copy shadow to active (new data if loaded same cycle)
//   feat_data/valid/ready feature window stream, same packing as wgt_data
//   out_data/valid/ready  result stream, channel 0 in the MSBs
module dwc_pe_mc
    import dwc_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int K_SIZE = DEF_K_SIZE,
    parameter int CH     = DEF_CH,
    parameter int BWIDTH = DEF_BWIDTH,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OWIDTH = DEF_OWIDTH,
    parameter int SH_W   = DEF_SH_W
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [SH_W-1:0]                    cfg_shift,
    input  logic                               cfg_relu,
    input  logic [CH*K_SIZE*K_SIZE*DWIDTH-1:0] wgt_data,
    input  logic [CH*BWIDTH-1:0]               wgt_bias,
    input  logic                               wgt_load,
    input  logic                               wgt_commit,
    input  logic [CH*K_SIZE*K_SIZE*DWIDTH-1:0] feat_data,
    input  logic                               feat_valid,
    output logic                               feat_ready,
    output logic [CH*OWIDTH-1:0]               out_data,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int K2      = K_SIZE * K_SIZE;
    localparam int CH_BITS = K2 * DWIDTH;
    localparam int W_BITS  = CH * CH_BITS;
    localparam int B_BITS  = CH * BWIDTH;

    genvar gi;

    generate
        if (!acc_w_legal(DWIDTH, K2, BWIDTH, ACC_W)) begin : g_bad_acc_w
            $error("dwc_pe_mc: ACC_W too narrow for DWIDTH/K_SIZE/BWIDTH");
        end
    endgenerate

    logic [W_BITS-1:0] shadow_w_reg;
    logic [B_BITS-1:0] shadow_b_reg;
    logic [W_BITS-1:0] active_w_reg;
    logic [B_BITS-1:0] active_b_reg;
    logic              v1_reg;
    logic              v2_reg;
    logic              v3_reg;
    logic              adv;

    // Weight banks run independently of the pipeline stall. A commit in the
    // same cycle as a load takes the incoming data directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_w_reg <= '0;
            shadow_b_reg <= '0;
            active_w_reg <= '0;
            active_b_reg <= '0;
        end else begin
            if (wgt_load) begin
                shadow_w_reg <= wgt_data;
                shadow_b_reg <= wgt_bias;
            end
            if (wgt_commit) begin
                active_w_reg <= wgt_load ? wgt_data : shadow_w_reg;
                active_b_reg <= wgt_load ? wgt_bias : shadow_b_reg;
            end
        end
    end

    // The whole pipeline moves when the output slot is empty or draining.
    assign adv        = !v3_reg || out_ready;
    assign feat_ready = !reset && adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else if (adv) begin
            v1_reg <= feat_valid;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
        end
    end

    assign out_valid = v3_reg;

    // One lane per channel; each samples the active bank at accept time, so
    // a commit landing on the accept edge leaves that beat on the old set.
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            localparam int WL = chan_lsb(gi, CH, CH_BITS);
            localparam int BL = chan_lsb(gi, CH, BWIDTH);
            localparam int OL = chan_lsb(gi, CH, OWIDTH);
            dwc_lane #(
                .DWIDTH (DWIDTH),
                .K2     (K2),
                .BWIDTH (BWIDTH),
                .ACC_W  (ACC_W),
                .OWIDTH (OWIDTH),
                .SH_W   (SH_W)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .adv       (adv),
                .wgt       (active_w_reg[WL +: CH_BITS]),
                .feat      (feat_data[WL +: CH_BITS]),
                .bias      (active_b_reg[BL +: BWIDTH]),
                .cfg_shift (cfg_shift),
                .cfg_relu  (cfg_relu),
                .result    (out_data[OL +: OWIDTH])
            );
        end
    endgenerate

endmodule
